// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan/compositor slice.
`default_nettype none
package vga_pkg;

  typedef logic [7:0] rgb8_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic logic [10:0] h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return 11'(act + fp + sync + bp);
  endfunction

  function automatic logic [10:0] v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return 11'(act + fp + sync + bp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
// Raster counters with raw (undelayed) active/sync flags and the vblank_start pulse.
`default_nettype none
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        active,
  output logic        hs_raw,
  output logic        vs_raw,
  output logic        vblank_start
);

  localparam logic [10:0] H_LAST   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 11'd1;
  localparam logic [10:0] V_LAST   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 11'd1;
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt        <= 11'd0;
      v_cnt        <= 11'd0;
      vblank_start <= 1'b0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= 11'd0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
      // Fires on the cycle after the scan enters the first blanking line.
      vblank_start <= (h_cnt == 11'd0) && (v_cnt == V_ACT);
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));

endmodule
`default_nettype wire

// File: rtl/vga_scan_compositor.sv
// Drives scan coordinates to the drawers, delays timing to match their latency and
// composites their requests by fixed priority (layer 0 highest) onto the VGA pins.
`default_nettype none
module vga_scan_compositor
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned N_LAYERS     = 4,
  parameter int unsigned DRAW_LATENCY = 1,
  parameter rgb8_t       BG_COLOR     = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [10:0]           oCoord_X,
  output logic [10:0]           oCoord_Y,
  input  logic [N_LAYERS-1:0]   draw_req,
  input  logic [8*N_LAYERS-1:0] layer_RGB,
  output rgb8_t                 mVGA_RGB,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  vblank_start
);

  localparam int LAST = DRAW_LATENCY - 1;

  logic                    active;
  logic                    hs_raw;
  logic                    vs_raw;
  logic [DRAW_LATENCY-1:0] act_pipe;
  logic [DRAW_LATENCY-1:0] hs_pipe;
  logic [DRAW_LATENCY-1:0] vs_pipe;
  rgb8_t                   pixel;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (CLK),
    .rst          (RESET),
    .h_cnt        (oCoord_X),
    .v_cnt        (oCoord_Y),
    .active       (active),
    .hs_raw       (hs_raw),
    .vs_raw       (vs_raw),
    .vblank_start (vblank_start)
  );

  // Timing flags ride alongside the drawers so they meet the matching draw_req.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      act_pipe[0] <= active;
      hs_pipe[0]  <= hs_raw;
      vs_pipe[0]  <= vs_raw;
      for (int i = 1; i < DRAW_LATENCY; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  // Scan from the lowest priority upward so the lowest set index overwrites last.
  always_comb begin
    pixel = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (draw_req[i]) pixel = layer_RGB[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mVGA_RGB    <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      mVGA_RGB    <= act_pipe[LAST] ? pixel : 8'h00;
      VGA_HS      <= hs_pipe[LAST];
      VGA_VS      <= vs_pipe[LAST];
      VGA_BLANK_N <= act_pipe[LAST];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_compositor.sv
// Randomized drawer traffic against a pixel-index reference model, for a default
// 640x480 instance (latency 1) and a reduced-timing instance (latency 3).
`default_nettype none
module tb_vga_scan_compositor;

  localparam int HA [2] = '{640, 40};
  localparam int HFP[2] = '{16, 4};
  localparam int HSY[2] = '{96, 8};
  localparam int HBP[2] = '{48, 6};
  localparam int VA [2] = '{480, 20};
  localparam int VFP[2] = '{10, 2};
  localparam int VSY[2] = '{2, 2};
  localparam int VBP[2] = '{33, 3};
  localparam int LAT[2] = '{1, 3};
  localparam logic [7:0] BG[2] = '{8'h00, 8'h25};

  logic        CLK = 1'b0;
  logic        RESET;
  logic [10:0] cx [2];
  logic [10:0] cy [2];
  logic [7:0]  rgb[2];
  logic        hs [2];
  logic        vs [2];
  logic        bl [2];
  logic        vb [2];
  logic [3:0]  req[2];
  logic [31:0] lrgb[2];

  logic [3:0]  rh[2][8];
  logic [31:0] ch[2][8];

  int compared   = 0;
  int mismatched = 0;
  int m          = 0;
  int hs_run     = 0;
  int vs_run     = 0;
  bit phase2     = 1'b0;

  always #5 CLK = ~CLK;

  vga_scan_compositor dut_a (
    .CLK(CLK), .RESET(RESET), .oCoord_X(cx[0]), .oCoord_Y(cy[0]),
    .draw_req(req[0]), .layer_RGB(lrgb[0]), .mVGA_RGB(rgb[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .vblank_start(vb[0])
  );

  vga_scan_compositor #(
    .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HSY[1]), .H_BP(HBP[1]),
    .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VSY[1]), .V_BP(VBP[1]),
    .N_LAYERS(4), .DRAW_LATENCY(LAT[1]), .BG_COLOR(BG[1])
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .oCoord_X(cx[1]), .oCoord_Y(cy[1]),
    .draw_req(req[1]), .layer_RGB(lrgb[1]), .mVGA_RGB(rgb[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .vblank_start(vb[1])
  );

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL dut%0d %s at m=%0d: got %0h, expected %0h", k, nm, m, act, exp);
    end
  endtask

  function automatic logic [7:0] prio(input logic [3:0] r, input logic [31:0] c, input logic [7:0] bg);
    for (int i = 0; i < 4; i++) if (r[i]) return c[8*i +: 8];
    return bg;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int htot, vtot, x, y, j;
      logic ea, ehs, evs;
      logic [7:0] ergb;
      htot = HA[k] + HFP[k] + HSY[k] + HBP[k];
      vtot = VA[k] + VFP[k] + VSY[k] + VBP[k];
      chk(k, "coord_x", cx[k], (m % htot));
      chk(k, "coord_y", cy[k], ((m / htot) % vtot));
      if (m < LAT[k] + 1) begin
        ea = 1'b0; ehs = 1'b1; evs = 1'b1; ergb = 8'h00;
      end else begin
        j   = m - LAT[k] - 1;
        x   = j % htot;
        y   = (j / htot) % vtot;
        ea  = (x < HA[k]) && (y < VA[k]);
        ehs = !((x >= HA[k] + HFP[k]) && (x < HA[k] + HFP[k] + HSY[k]));
        evs = !((y >= VA[k] + VFP[k]) && (y < VA[k] + VFP[k] + VSY[k]));
        ergb = ea ? prio(rh[k][(m-1) % 8], ch[k][(m-1) % 8], BG[k]) : 8'h00;
      end
      chk(k, "rgb", rgb[k], ergb);
      chk(k, "hs", hs[k], ehs);
      chk(k, "vs", vs[k], evs);
      chk(k, "blank_n", bl[k], ea);
      chk(k, "vblank_start", vb[k], (m >= 1) && ((m - 1) % (htot * vtot) == VA[k] * htot));
    end
    // Sync pulse widths, measured directly on the pins.
    if (hs[0] === 1'b0) hs_run++;
    else begin
      if (hs_run != 0) chk(0, "hs_width", hs_run, 96);
      hs_run = 0;
    end
    if (vs[1] === 1'b0) vs_run++;
    else begin
      if (vs_run != 0) chk(1, "vs_width", vs_run, 2 * 58);
      vs_run = 0;
    end
    if (phase2) begin
      case (m)
        4011: chk(0, "lit_left_of_obj", rgb[0], 8'h00);
        4012: chk(0, "lit_obj_10_5", rgb[0], 8'hE0);
        4013: chk(0, "lit_right_of_obj", rgb[0], 8'h00);
        4822: chk(0, "lit_prio_0110", rgb[0], 8'h1C);
        4823: chk(0, "lit_no_req_bg", rgb[0], 8'h00);
        6302: begin
          chk(0, "lit_blank_rgb", rgb[0], 8'h00);
          chk(0, "lit_blank_n", bl[0], 1'b0);
        end
        8800: begin
          chk(0, "lit_wrap_x", cx[0], 11'd0);
          chk(0, "lit_wrap_y", cy[0], 11'd11);
        end
        default: ;
      endcase
      case (m)
        303:  chk(1, "lit_lat3_before", rgb[1], 8'h25);
        304:  chk(1, "lit_lat3_obj", rgb[1], 8'hE0);
        305:  chk(1, "lit_lat3_after", rgb[1], 8'h25);
        1160: chk(1, "lit_vblank_early", vb[1], 1'b0);
        1161: chk(1, "lit_vblank_pulse", vb[1], 1'b1);
        1566: begin
          chk(1, "lit_frame_wrap_x", cx[1], 11'd0);
          chk(1, "lit_frame_wrap_y", cy[1], 11'd0);
        end
        default: ;
      endcase
    end
  endtask

  // Drawer model: sees the coordinate LAT cycles ago and answers now.
  task automatic drive_all();
    for (int k = 0; k < 2; k++) begin
      int htot, s, sx, sy;
      logic [3:0]  r;
      logic [31:0] c;
      htot = HA[k] + HFP[k] + HSY[k] + HBP[k];
      s  = m - LAT[k];
      sx = (s >= 0) ? s % htot : -1;
      sy = (s >= 0) ? (s / htot) % (VA[k] + VFP[k] + VSY[k] + VBP[k]) : -1;
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      c  = $urandom;
      if (sy == 5) begin
        r = (sx == 10) ? 4'b0100 : 4'b0000;
        c[23:16] = 8'hE0;
      end else if (k == 0 && sy == 6) begin
        r = 4'b0000;
        if (sx == 20) begin
          r = 4'b0110;
          c[15:8]  = 8'h1C;
          c[23:16] = 8'hE0;
        end
      end else if (k == 0 && sy == 7) begin
        r = 4'b1111;
      end
      req[k]  = r;
      lrgb[k] = c;
      rh[k][m % 8] = r;
      ch[k][m % 8] = c;
    end
  endtask

  task automatic step();
    compare_all();
    drive_all();
    @(posedge CLK);
    if (!RESET) m++;
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k]  = 4'b0000;
      lrgb[k] = 32'h0;
    end
    repeat (3) @(negedge CLK);
    compare_all();
    RESET = 1'b0;

    repeat (3742) step();

    // Mid-frame reset on dut_b at (30,10); outputs must clear without waiting for an edge.
    compare_all();
    RESET = 1'b1;
    #1;
    m = 0;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_async_x", cx[k], 11'd0);
      chk(k, "rst_async_y", cy[k], 11'd0);
      chk(k, "rst_async_rgb", rgb[k], 8'h00);
      chk(k, "rst_async_hs", hs[k], 1'b1);
      chk(k, "rst_async_vs", vs[k], 1'b1);
      chk(k, "rst_async_blank", bl[k], 1'b0);
      chk(k, "rst_async_vblank", vb[k], 1'b0);
    end
    hs_run = 0;
    vs_run = 0;
    repeat (3) begin
      drive_all();
      @(posedge CLK);
      @(negedge CLK);
      compare_all();
    end
    RESET  = 1'b0;
    phase2 = 1'b1;

    repeat (9000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
